// File: rtl/ram_512x8_pkg.sv
// Shared constants for the 512x8 big-endian data memory: access-size codes and geometry defaults.
package ram_512x8_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 512;
  localparam int unsigned ADDR_W_DEFAULT = 9;
  localparam int unsigned DATA_W         = 32;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

endpackage

// File: rtl/ram_512x8_rdfmt.sv
// Load formatter: packs the four big-endian byte lanes into a 32-bit result,
// zero- or sign-extending byte and halfword loads.
module ram_512x8_rdfmt
  import ram_512x8_pkg::*;
(
  input  logic [7:0]  b0_i,
  input  logic [7:0]  b1_i,
  input  logic [7:0]  b2_i,
  input  logic [7:0]  b3_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  logic ext;
  assign ext = sign_ext_i & b0_i[7];

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_BYTE:              data_o = {{24{ext}}, b0_i};
      SZ_HALF:              data_o = {{16{ext}}, b0_i, b1_i};
      SZ_WORD, SZ_WORD_ALT: data_o = {b0_i, b1_i, b2_i, b3_i};
      // Unknown size codes read as zero
      default:              data_o = '0;
    endcase
  end

endmodule

// File: rtl/ram_512x8.sv
// 512-byte big-endian data memory: combinational read, posedge write, addresses wrap modulo DEPTH.
// Define RAM_ALIGN_FORCE_EN to force halfword/word effective addresses to natural alignment.
module ram_512x8
  import ram_512x8_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] DataOut,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic              SignExtend,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [1:0]        Size
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        Mem [0:DEPTH-1];
  logic [ADDR_W-1:0] addr_eff;
  logic [ADDR_W-1:0] lane_addr [4];
  logic [7:0]        lane_byte [4];
  logic [ADDR_W:0]   sum;
  logic [DATA_W-1:0] fmt_data;
  logic              rd_en;
  logic              wr_en;

  always_comb begin
    addr_eff = Address;
`ifdef RAM_ALIGN_FORCE_EN
    case (Size)
      SZ_HALF:              addr_eff = {Address[ADDR_W-1:1], 1'b0};
      SZ_WORD, SZ_WORD_ALT: addr_eff = {Address[ADDR_W-1:2], 2'b00};
      default:              addr_eff = Address;
    endcase
`endif
  end

  // Lane k sits at addr_eff + k, wrapped back into [0, DEPTH)
  always_comb begin
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      sum = {1'b0, addr_eff} + (ADDR_W + 1)'(k);
      if (sum >= DepthW) sum = sum - DepthW;
      lane_addr[k] = sum[ADDR_W-1:0];
      lane_byte[k] = Mem[lane_addr[k]];
    end
  end

  assign rd_en = rst_n & Enable & ~ReadWrite;
  assign wr_en = rst_n & Enable & ReadWrite;

  ram_512x8_rdfmt u_rdfmt (
    .b0_i       (lane_byte[0]),
    .b1_i       (lane_byte[1]),
    .b2_i       (lane_byte[2]),
    .b3_i       (lane_byte[3]),
    .size_i     (Size),
    .sign_ext_i (SignExtend),
    .data_o     (fmt_data)
  );

  assign DataOut = rd_en ? fmt_data : '0;

  // Storage has no reset; contents survive rst_n
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (Size)
        SZ_BYTE: Mem[lane_addr[0]] <= DataIn[7:0];
        SZ_HALF: begin
          Mem[lane_addr[0]] <= DataIn[15:8];
          Mem[lane_addr[1]] <= DataIn[7:0];
        end
        SZ_WORD, SZ_WORD_ALT: begin
          Mem[lane_addr[0]] <= DataIn[31:24];
          Mem[lane_addr[1]] <= DataIn[23:16];
          Mem[lane_addr[2]] <= DataIn[15:8];
          Mem[lane_addr[3]] <= DataIn[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_512x8.sv
// Directed self-checking bench for ram_512x8: formatted loads, stores, reset gating and wrap.
module tb_ram_512x8;

  logic        clk;
  logic        rst_n;
  logic [31:0] DataOut;
  logic        Enable;
  logic        ReadWrite;
  logic        SignExtend;
  logic [8:0]  Address;
  logic [31:0] DataIn;
  logic [1:0]  Size;

  int checks;
  int errors;

  ram_512x8 ram1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .DataOut    (DataOut),
    .Enable     (Enable),
    .ReadWrite  (ReadWrite),
    .SignExtend (SignExtend),
    .Address    (Address),
    .DataIn     (DataIn),
    .Size       (Size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic preload();
    logic [7:0] init [12];
    init = '{8'h8A, 8'h5C, 8'h01, 8'hF3, 8'h7E, 8'h00, 8'hFF, 8'h10,
             8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 12; i++) ram1.Mem[i] = init[i];
    ram1.Mem[508] = 8'h12;
    ram1.Mem[509] = 8'h34;
    ram1.Mem[510] = 8'hAA;
    ram1.Mem[511] = 8'hBB;
  endtask

  task automatic test_reset();
    Enable = 1'b1; ReadWrite = 1'b0; SignExtend = 1'b0; Size = 2'b11;
    Address = 9'd0; DataIn = 32'h0;
    #1;
    checks++;
    if (DataOut !== 32'h0) begin
      errors++; $display("FAIL reset_out got %h exp %h", DataOut, 32'h0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (DataOut !== 32'h8A5C01F3) begin
      errors++; $display("FAIL post_reset_read got %h exp %h", DataOut, 32'h8A5C01F3);
    end
    Enable = 1'b0;
    #1;
    checks++;
    if (DataOut !== 32'h0) begin
      errors++; $display("FAIL disabled_out got %h exp %h", DataOut, 32'h0);
    end
    Enable = 1'b1; ReadWrite = 1'b1;
    #1;
    checks++;
    if (DataOut !== 32'h0) begin
      errors++; $display("FAIL write_mode_out got %h exp %h", DataOut, 32'h0);
    end
    ReadWrite = 1'b0;
  endtask

  task automatic test_word_read();
    logic [8:0]  addr [4];
    logic [1:0]  sz   [4];
    logic [31:0] exp  [4];
    addr = '{9'd0, 9'd4, 9'd8, 9'd0};
    sz   = '{2'b11, 2'b11, 2'b11, 2'b10};
    exp  = '{32'h8A5C01F3, 32'h7E00FF10, 32'h11223344, 32'h8A5C01F3};
    for (int i = 0; i < 4; i++) begin
      Address = addr[i]; Size = sz[i]; SignExtend = 1'b1;
      #1;
      checks++;
      if (DataOut !== exp[i]) begin
        errors++; $display("FAIL word_read[%0d] got %h exp %h", i, DataOut, exp[i]);
      end
    end
  endtask

  task automatic test_byte_read();
    logic [8:0]  addr [4];
    logic        se   [4];
    logic [31:0] exp  [4];
    addr = '{9'd0, 9'd0, 9'd4, 9'd6};
    se   = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp  = '{32'h0000008A, 32'hFFFFFF8A, 32'h0000007E, 32'h000000FF};
    Size = 2'b00;
    for (int i = 0; i < 4; i++) begin
      Address = addr[i]; SignExtend = se[i];
      #1;
      checks++;
      if (DataOut !== exp[i]) begin
        errors++; $display("FAIL byte_read[%0d] got %h exp %h", i, DataOut, exp[i]);
      end
    end
  endtask

  task automatic test_half_read();
    logic [8:0]  addr [3];
    logic        se   [3];
    logic [31:0] exp  [3];
    addr = '{9'd2, 9'd0, 9'd0};
    se   = '{1'b1, 1'b1, 1'b0};
    exp  = '{32'h000001F3, 32'hFFFF8A5C, 32'h00008A5C};
    Size = 2'b01;
    for (int i = 0; i < 3; i++) begin
      Address = addr[i]; SignExtend = se[i];
      #1;
      checks++;
      if (DataOut !== exp[i]) begin
        errors++; $display("FAIL half_read[%0d] got %h exp %h", i, DataOut, exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_word;
    logic [31:0] exp_half;
`ifdef RAM_ALIGN_FORCE_EN
    exp_word = 32'h1234AABB;
    exp_half = 32'h0000AABB;
`else
    exp_word = 32'hAABB8A5C;
    exp_half = 32'h0000BB8A;
`endif
    Address = 9'd510; Size = 2'b10; SignExtend = 1'b0;
    #1;
    checks++;
    if (DataOut !== exp_word) begin
      errors++; $display("FAIL wrap_word got %h exp %h", DataOut, exp_word);
    end
    Address = 9'd511; Size = 2'b01;
    #1;
    checks++;
    if (DataOut !== exp_half) begin
      errors++; $display("FAIL wrap_half got %h exp %h", DataOut, exp_half);
    end
  endtask

  task automatic test_write();
    logic [8:0]  waddr [3];
    logic [1:0]  wsz   [3];
    logic [31:0] wdat  [3];
    logic [31:0] exp   [3];
    waddr = '{9'd0, 9'd2, 9'd8};
    wsz   = '{2'b00, 2'b01, 2'b10};
    wdat  = '{32'h000000A6, 32'h0000BBCC, 32'hAEEABBA6};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Enable = 1'b1; ReadWrite = 1'b1;
      Address = waddr[i]; Size = wsz[i]; DataIn = wdat[i];
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    ReadWrite = 1'b0; Size = 2'b11;
    exp = '{32'hA65CBBCC, 32'h7E00FF10, 32'hAEEABBA6};
    for (int i = 0; i < 3; i++) begin
      Address = 9'(i * 4);
      #1;
      checks++;
      if (DataOut !== exp[i]) begin
        errors++; $display("FAIL write_readback[%0d] got %h exp %h", i, DataOut, exp[i]);
      end
    end
  endtask

  task automatic test_reset_write();
    @(negedge clk);
    Enable = 1'b1; ReadWrite = 1'b1; Size = 2'b10;
    Address = 9'd0; DataIn = 32'hDEADBEEF;
    rst_n = 1'b0;
    #1;
    checks++;
    if (DataOut !== 32'h0) begin
      errors++; $display("FAIL reset_during_write got %h exp %h", DataOut, 32'h0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    ReadWrite = 1'b0; Size = 2'b11;
    rst_n = 1'b1;
    #1;
    checks++;
    if (DataOut !== 32'hA65CBBCC) begin
      errors++; $display("FAIL reset_blocks_write got %h exp %h", DataOut, 32'hA65CBBCC);
    end
    // Asserting reset mid-cycle must zero the read path at once
    rst_n = 1'b0;
    #1;
    checks++;
    if (DataOut !== 32'h0) begin
      errors++; $display("FAIL midcycle_reset got %h exp %h", DataOut, 32'h0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    preload();
    test_reset();
    test_word_read();
    test_byte_read();
    test_half_read();
    test_wrap();
    test_write();
    test_reset_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
